// File: rtl/operand_fetch_pkg.sv
// Shared constants, register index type and operand bundle layout for the
// operand fetch stage and its scoreboard.
package operand_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned PW   = 16;

    typedef logic [AW-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = AW'(0);

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        reg_idx_t        rd;
        logic            rd_we;
        logic [PW-1:0]   payload;
    } of_bundle_t;

    // x0 reads zero; a same-cycle writeback to the source beats the stale RF read.
    function automatic logic [XLEN-1:0] resolve_src(
        input reg_idx_t        idx,
        input logic            wb_hit,
        input logic [XLEN-1:0] wb_data,
        input logic [XLEN-1:0] rf_data
    );
        logic [XLEN-1:0] val;
        val = rf_data;
        if (idx == REG_ZERO) begin
            val = XLEN'(0);
        end else if (wb_hit) begin
            val = wb_data;
        end
        return val;
    endfunction

endpackage

// File: rtl/operand_fetch_reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register,
// set on issue of a writer, cleared on writeback; set wins, x0 never busy.
module reg_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en,
    input  reg_idx_t        set_idx,
    input  logic            clr_en,
    input  reg_idx_t        clr_idx,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    // Clear is applied before set so a same-index collision leaves the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        if (clr_en) begin
            w_busy_nxt[clr_idx] = 1'b0;
        end
        if (set_en) begin
            w_busy_nxt[set_idx] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy = r_busy;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: drives RF read ports, bypasses writeback data, stalls on
// RAW/WAW hazards and holds resolved operands in a one-entry output slot.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  reg_idx_t        in_rs1,
    input  reg_idx_t        in_rs2,
    input  reg_idx_t        in_rd,
    input  logic            in_rd_we,
    input  logic [PW-1:0]   in_payload,
    output reg_idx_t        rf_raddr1,
    output reg_idx_t        rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_valid,
    input  reg_idx_t        wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output reg_idx_t        out_rd,
    output logic            out_rd_we,
    output logic [PW-1:0]   out_payload
);

    logic [NREG-1:0] w_busy;
    logic            w_src1_hit;
    logic            w_src2_hit;
    logic            w_rd_live;
    logic            w_rd_hit;
    logic            w_hazard;
    logic            w_slot_free;
    logic            w_ready;
    logic            w_accept;
    of_bundle_t      w_bundle_nxt;

    logic            r_out_valid;
    of_bundle_t      r_bundle;

    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;

    // Hazard detection: a pending source or destination stalls unless it is
    // being written back in this very cycle.
    always_comb begin
        w_src1_hit  = wb_valid && (wb_rd == in_rs1) && (in_rs1 != REG_ZERO);
        w_src2_hit  = wb_valid && (wb_rd == in_rs2) && (in_rs2 != REG_ZERO);
        w_rd_live   = in_rd_we && (in_rd != REG_ZERO);
        w_rd_hit    = wb_valid && (wb_rd == in_rd);
        w_hazard    = (w_busy[in_rs1] && !w_src1_hit)
                    || (w_busy[in_rs2] && !w_src2_hit)
                    || (w_rd_live && w_busy[in_rd] && !w_rd_hit);
        w_slot_free = !r_out_valid || out_ready;
        w_ready     = w_slot_free && !w_hazard;
        w_accept    = in_valid && w_ready;
    end

    assign in_ready = w_ready;

    always_comb begin
        w_bundle_nxt         = '0;
        w_bundle_nxt.op1     = resolve_src(in_rs1, w_src1_hit, wb_data, rf_rdata1);
        w_bundle_nxt.op2     = resolve_src(in_rs2, w_src2_hit, wb_data, rf_rdata2);
        w_bundle_nxt.rd      = in_rd;
        w_bundle_nxt.rd_we   = w_rd_live;
        w_bundle_nxt.payload = in_payload;
    end

    reg_scoreboard u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (w_accept && w_rd_live),
        .set_idx (in_rd),
        .clr_en  (wb_valid),
        .clr_idx (wb_rd),
        .busy    (w_busy)
    );

    // Output slot: load on accept, drain on handshake, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_bundle    <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_bundle    <= w_bundle_nxt;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_op1     = r_bundle.op1;
    assign out_op2     = r_bundle.op2;
    assign out_rd      = r_bundle.rd;
    assign out_rd_we   = r_bundle.rd_we;
    assign out_payload = r_bundle.payload;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: architectural model (register file + pending set +
// expected slot) checked every cycle, plus directed literal expectations.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    reg_idx_t        in_rs1;
    reg_idx_t        in_rs2;
    reg_idx_t        in_rd;
    logic            in_rd_we;
    logic [PW-1:0]   in_payload;
    reg_idx_t        rf_raddr1;
    reg_idx_t        rf_raddr2;
    logic [XLEN-1:0] rf_rdata1;
    logic [XLEN-1:0] rf_rdata2;
    logic            wb_valid;
    reg_idx_t        wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    reg_idx_t        out_rd;
    logic            out_rd_we;
    logic [PW-1:0]   out_payload;

    int n_checks = 0;
    int n_errors = 0;

    operand_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rd       (in_rd),
        .in_rd_we    (in_rd_we),
        .in_payload  (in_payload),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op1     (out_op1),
        .out_op2     (out_op2),
        .out_rd      (out_rd),
        .out_rd_we   (out_rd_we),
        .out_payload (out_payload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural state the bench believes in.
    logic [XLEN-1:0] rf [NREG];
    logic            rf_loaded = 1'b0;
    logic [NREG-1:0] pending;
    logic            exp_valid;
    logic [XLEN-1:0] exp_op1;
    logic [XLEN-1:0] exp_op2;
    reg_idx_t        exp_rd;
    logic            exp_rd_we;
    logic [PW-1:0]   exp_payload;

    assign rf_rdata1 = (rf_raddr1 == REG_ZERO) ? XLEN'(0) : rf[rf_raddr1];
    assign rf_rdata2 = (rf_raddr2 == REG_ZERO) ? XLEN'(0) : rf[rf_raddr2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic written_now(input reg_idx_t r);
        return wb_valid && (wb_rd == r);
    endfunction

    function automatic logic reg_blocked(input reg_idx_t r);
        return (r != REG_ZERO) && pending[r] && !written_now(r);
    endfunction

    function automatic logic model_ready();
        logic blocked;
        blocked = reg_blocked(in_rs1) || reg_blocked(in_rs2)
               || (in_rd_we && reg_blocked(in_rd));
        return !(exp_valid && !out_ready) && !blocked;
    endfunction

    // Architectural value of a source, including this cycle's writeback.
    function automatic logic [XLEN-1:0] arch_val(input reg_idx_t r);
        if (r == REG_ZERO) return XLEN'(0);
        if (written_now(r)) return wb_data;
        return rf[r];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     = '0;
            exp_valid   = 1'b0;
            exp_op1     = '0;
            exp_op2     = '0;
            exp_rd      = '0;
            exp_rd_we   = 1'b0;
            exp_payload = '0;
            if (!rf_loaded) begin
                for (int i = 0; i < int'(NREG); i++) rf[i] <= XLEN'(32'h1000 + i);
                rf[3] <= 32'h11;
                rf[4] <= 32'h22;
                rf_loaded = 1'b1;
            end
        end else begin
            logic acc;
            acc = in_valid && model_ready();
            if (acc) begin
                exp_valid   = 1'b1;
                exp_op1     = arch_val(in_rs1);
                exp_op2     = arch_val(in_rs2);
                exp_rd      = in_rd;
                exp_rd_we   = in_rd_we && (in_rd != REG_ZERO);
                exp_payload = in_payload;
            end else if (out_ready) begin
                exp_valid = 1'b0;
            end
            if (wb_valid) pending[wb_rd] = 1'b0;
            if (acc && in_rd_we && (in_rd != REG_ZERO)) pending[in_rd] = 1'b1;
            if (wb_valid && (wb_rd != REG_ZERO)) rf[wb_rd] <= wb_data;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 32'(in_ready), 32'(model_ready()));
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            chk("busy", dut.u_scoreboard.busy, pending);
            if (exp_valid) begin
                chk("out_op1", out_op1, exp_op1);
                chk("out_op2", out_op2, exp_op2);
                chk("out_rd", 32'(out_rd), 32'(exp_rd));
                chk("out_rd_we", 32'(out_rd_we), 32'(exp_rd_we));
                chk("out_payload", 32'(out_payload), 32'(exp_payload));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input reg_idx_t rs1, input reg_idx_t rs2,
                         input reg_idx_t rd, input logic we, input logic [PW-1:0] pl);
        in_valid   = v;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rd      = rd;
        in_rd_we   = we;
        in_payload = pl;
    endtask

    task automatic wb(input logic v, input reg_idx_t rd, input logic [XLEN-1:0] d);
        wb_valid = v;
        wb_rd    = rd;
        wb_data  = d;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0);
        wb(1'b0, 5'd0, 32'h0);
        repeat (3) step();
        at_neg();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_op1", out_op1, 32'h0);
        chk("rst_out_payload", 32'(out_payload), 32'h0);
        step();
        rst_n = 1'b1;

        // Basic read of x3/x4.
        issue(1'b1, 5'd3, 5'd4, 5'd1, 1'b0, 16'hA1);
        step();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0);
        at_neg();
        chk("basic_valid", 32'(out_valid), 32'h1);
        chk("basic_op1", out_op1, 32'h11);
        chk("basic_op2", out_op2, 32'h22);

        // RAW on x5 resolved through the writeback bypass.
        issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 16'hA2);
        step();
        issue(1'b1, 5'd5, 5'd4, 5'd6, 1'b0, 16'hA3);
        at_neg();
        chk("raw_stall", 32'(in_ready), 32'h0);
        step();
        step();
        wb(1'b1, 5'd5, 32'hDEAD);
        at_neg();
        chk("raw_release", 32'(in_ready), 32'h1);
        step();
        wb(1'b0, 5'd0, 32'h0);
        issue(1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 16'h0);
        at_neg();
        chk("raw_op1", out_op1, 32'hDEAD);
        chk("raw_op2", out_op2, 32'h22);
        chk("raw_cleared", 32'(in_ready), 32'h1);

        // x0 sources ignore a writeback aimed at x0; x0 writer is not tracked.
        issue(1'b1, 5'd0, 5'd0, 5'd8, 1'b0, 16'hA4);
        wb(1'b1, 5'd0, 32'hFFFF);
        at_neg();
        chk("x0_no_stall", 32'(in_ready), 32'h1);
        step();
        wb(1'b0, 5'd0, 32'h0);
        issue(1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 16'hA5);
        at_neg();
        chk("x0_op1", out_op1, 32'h0);
        chk("x0_op2", out_op2, 32'h0);
        step();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0);
        at_neg();
        chk("x0_rd_we", 32'(out_rd_we), 32'h0);
        chk("x0_busy", dut.u_scoreboard.busy, 32'h0);

        // Backpressure hold for three cycles, then same-cycle accept on release.
        issue(1'b1, 5'd3, 5'd0, 5'd1, 1'b0, 16'hB1);
        step();
        out_ready = 1'b0;
        issue(1'b1, 5'd4, 5'd3, 5'd2, 1'b0, 16'hB2);
        for (int k = 0; k < 3; k++) begin
            at_neg();
            chk("hold_payload", 32'(out_payload), 32'hB1);
            chk("hold_op1", out_op1, 32'h11);
            chk("hold_in_ready", 32'(in_ready), 32'h0);
            step();
        end
        out_ready = 1'b1;
        at_neg();
        chk("release_in_ready", 32'(in_ready), 32'h1);
        step();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0);
        at_neg();
        chk("release_payload", 32'(out_payload), 32'hB2);
        chk("release_op1", out_op1, 32'h22);

        // WAW on x7: second writer waits, issues on the writeback, set wins.
        issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 16'hC1);
        step();
        issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 16'hC2);
        at_neg();
        chk("waw_stall", 32'(in_ready), 32'h0);
        step();
        wb(1'b1, 5'd7, 32'h77);
        at_neg();
        chk("waw_release", 32'(in_ready), 32'h1);
        step();
        wb(1'b0, 5'd0, 32'h0);
        issue(1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 16'h0);
        at_neg();
        chk("waw_payload", 32'(out_payload), 32'hC2);
        chk("waw_still_busy", 32'(in_ready), 32'h0);
        wb(1'b1, 5'd7, 32'h78);
        step();
        wb(1'b0, 5'd0, 32'h0);

        // Asynchronous reset while a bundle is held and x9 is pending.
        issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 16'hD1);
        step();
        out_ready = 1'b0;
        issue(1'b1, 5'd9, 5'd0, 5'd2, 1'b0, 16'hD2);
        step();
        at_neg();
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_busy", dut.u_scoreboard.busy, 32'h0);
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0);
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        issue(1'b1, 5'd9, 5'd0, 5'd2, 1'b0, 16'hD3);
        at_neg();
        chk("post_rst_ready", 32'(in_ready), 32'h1);
        step();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0);
        at_neg();
        chk("post_rst_op1", out_op1, 32'h1009);

        // Back-to-back independent issue at full rate.
        for (int i = 0; i < 6; i++) begin
            issue(1'b1, 5'(i + 1), 5'(i + 2), 5'(10 + i), 1'b1, 16'(16'hE0 + i));
            step();
        end
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0);
        at_neg();
        chk("stream_last", 32'(out_payload), 32'hE5);

        // Mixed traffic with hazards, writebacks and backpressure.
        for (int i = 0; i < 80; i++) begin
            issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                  5'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 16'($urandom));
            wb(($urandom_range(0, 2) != 0), 5'($urandom_range(0, 15)), 32'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0);
        wb(1'b0, 5'd0, 32'h0);
        out_ready = 1'b1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
